// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing REG0/REG1 (RW), a write counter and an ID word; B follows the commit edge, R follows AR by one cycle.
// Each channel stalls (ready low) from its handshake until its response handshakes; B and R hold their payload until bready/rready.
module axi_lite_reg_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           ID_VALUE   = 32'hA110_0001
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [RESP_WIDTH-1:0]     s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [RESP_WIDTH-1:0]     s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [2:0] {SEL_REG0, SEL_REG1, SEL_WCOUNT, SEL_ID, SEL_NONE} sel_t;

    // Misaligned addresses never equal one of the four offsets, so they fall to SEL_NONE.
    function automatic sel_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        case (off)
            ADDR_WIDTH'(8'h00): return SEL_REG0;
            ADDR_WIDTH'(8'h04): return SEL_REG1;
            ADDR_WIDTH'(8'h08): return SEL_WCOUNT;
            ADDR_WIDTH'(8'h0C): return SEL_ID;
            default:            return SEL_NONE;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_val,
                                                     input logic [DATA_WIDTH-1:0] new_val,
                                                     input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    wstate_t                 wstate_q, wstate_d;
    rstate_t                 rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    arready_q, arready_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
    logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   reg0_q, reg0_d;
    logic [DATA_WIDTH-1:0]   reg1_q, reg1_d;
    logic [15:0]             wcount_q, wcount_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_data;
    logic [STRB_WIDTH-1:0]   c_strb;
    sel_t                    w_sel, r_sel;

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        reg0_d   = reg0_q;
        reg1_d   = reg1_q;
        wcount_d = wcount_q;
        commit   = 1'b0;
        w_sel    = SEL_NONE;

        aw_hs = s_axi_awvalid && awready_q;
        w_hs  = s_axi_wvalid && wready_q;

        // Whichever half arrived first comes from the latch, the other straight off the bus.
        c_addr = (wstate_q == W_HAVE_AW) ? awaddr_q : s_axi_awaddr;
        c_data = (wstate_q == W_HAVE_W)  ? wdata_q  : s_axi_wdata;
        c_strb = (wstate_q == W_HAVE_W)  ? wstrb_q  : s_axi_wstrb;

        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    awaddr_d = s_axi_awaddr;
                    wstate_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs)  commit = 1'b1;
            W_HAVE_W:  if (aw_hs) commit = 1'b1;
            W_RESP:    if (s_axi_bready) wstate_d = W_IDLE;
            default:   wstate_d = W_IDLE;
        endcase

        if (commit) begin
            wstate_d = W_RESP;
            w_sel    = decode(c_addr);
            bresp_d  = RESP_SLVERR;
            if (w_sel == SEL_REG0 || w_sel == SEL_REG1) begin
                bresp_d  = RESP_OKAY;
                wcount_d = wcount_q + 16'd1;
                if (w_sel == SEL_REG0) reg0_d = merge(reg0_q, c_data, c_strb);
                else                   reg1_d = merge(reg1_q, c_data, c_strb);
            end
        end

        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
    end

    // Read data is captured from the pre-edge register values, so a same-edge write is not visible.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        r_sel    = SEL_NONE;
        ar_hs    = s_axi_arvalid && arready_q;

        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    r_sel    = decode(s_axi_araddr);
                    rresp_d  = RESP_OKAY;
                    case (r_sel)
                        SEL_REG0:   rdata_d = reg0_q;
                        SEL_REG1:   rdata_d = reg1_q;
                        SEL_WCOUNT: rdata_d = DATA_WIDTH'(wcount_q);
                        SEL_ID:     rdata_d = DATA_WIDTH'(ID_VALUE);
                        default: begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                end
            end
            R_DATA:  if (s_axi_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase

        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            reg0_q    <= '0;
            reg1_q    <= '0;
            wcount_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            reg0_q    <= reg0_d;
            reg1_q    <= reg1_d;
            wcount_q  <= wcount_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed vector table, hand-written corner sequences, and randomized traffic against a register-map model.
module tb_axi_lite_reg_slave;

    localparam int          BASE = 0;
    localparam logic [31:0] ID   = 32'hA110_0001;

    logic        s_axi_aclk, s_axi_areset;
    logic [7:0]  s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [2:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;

    axi_lite_reg_slave dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    initial begin
        s_axi_aclk = 1'b0;
        forever #5 s_axi_aclk = ~s_axi_aclk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Register-map model: byte-enabled RW words, a mod-65536 OKAY-write counter, a constant ID.
    logic [31:0] m_reg [2];
    int unsigned m_wcount;

    function automatic void m_reset();
        m_reg[0] = 32'h0;
        m_reg[1] = 32'h0;
        m_wcount = 0;
    endfunction

    function automatic logic [2:0] m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int off;
        off = (int'(a) - BASE) & 255;
        if (off == 0 || off == 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_reg[off / 4][8*b +: 8] = d[8*b +: 8];
            m_wcount = (m_wcount + 1) % 65536;
            return 3'd0;
        end
        return 3'd2;
    endfunction

    function automatic logic [2:0] m_read(input logic [7:0] a, output logic [31:0] d);
        int off;
        off = (int'(a) - BASE) & 255;
        case (off)
            0:  d = m_reg[0];
            4:  d = m_reg[1];
            8:  d = 32'(m_wcount);
            12: d = ID;
            default: begin
                d = 32'h0;
                return 3'd2;
            end
        endcase
        return 3'd0;
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [2:0] exp_resp, input string tag);
        bit aw_done, w_done, aw_fire, w_fire;
        int c;
        aw_done = 0; w_done = 0; c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge s_axi_aclk);
            s_axi_awaddr  = a;
            s_axi_wdata   = d;
            s_axi_wstrb   = s;
            s_axi_awvalid = !aw_done && (c >= aw_dly);
            s_axi_wvalid  = !w_done && (c >= w_dly);
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            @(posedge s_axi_aclk);
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            c++;
        end
        @(negedge s_axi_aclk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check($sformatf("%s aw/w accepted", tag), 32'({aw_done, w_done}), 32'h3);
        check($sformatf("%s bvalid after commit", tag), 32'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 32'h4);
        check($sformatf("%s bresp", tag), 32'(s_axi_bresp), 32'(exp_resp));
        for (int i = 0; i < b_dly; i++) begin
            @(negedge s_axi_aclk);
            check($sformatf("%s stall%0d bvalid/awready/wready", tag, i),
                  32'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 32'h4);
            check($sformatf("%s stall%0d bresp", tag, i), 32'(s_axi_bresp), 32'(exp_resp));
        end
        s_axi_bready = 1'b1;
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        s_axi_bready = 1'b0;
        check($sformatf("%s after B bvalid/awready/wready", tag),
              32'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 32'h3);
    endtask

    task automatic do_read(input logic [7:0] a, input int r_dly, input logic [31:0] exp_d,
                           input logic [2:0] exp_r, input string tag);
        bit fired, fire_now;
        int c;
        fired = 0; c = 0;
        while (!fired && c < 50) begin
            @(negedge s_axi_aclk);
            s_axi_araddr  = a;
            s_axi_arvalid = 1'b1;
            fire_now = s_axi_arready;
            @(posedge s_axi_aclk);
            fired = fire_now;
            c++;
        end
        @(negedge s_axi_aclk);
        s_axi_arvalid = 1'b0;
        check($sformatf("%s ar accepted", tag), 32'(fired), 32'h1);
        check($sformatf("%s rvalid/arready one cycle later", tag), 32'({s_axi_rvalid, s_axi_arready}), 32'h2);
        check($sformatf("%s rdata", tag), s_axi_rdata, exp_d);
        check($sformatf("%s rresp", tag), 32'(s_axi_rresp), 32'(exp_r));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge s_axi_aclk);
            check($sformatf("%s stall%0d rvalid/arready", tag, i), 32'({s_axi_rvalid, s_axi_arready}), 32'h2);
            check($sformatf("%s stall%0d rdata", tag, i), s_axi_rdata, exp_d);
            check($sformatf("%s stall%0d rresp", tag, i), 32'(s_axi_rresp), 32'(exp_r));
        end
        s_axi_rready = 1'b1;
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        s_axi_rready = 1'b0;
        check($sformatf("%s after R rvalid/arready", tag), 32'({s_axi_rvalid, s_axi_arready}), 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s readies/valids", tag),
              32'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}), 32'h0);
        check($sformatf("%s bresp/rresp", tag), 32'({s_axi_bresp, s_axi_rresp}), 32'h0);
        check($sformatf("%s rdata", tag), s_axi_rdata, 32'h0);
    endtask

    task automatic model_read(input logic [7:0] a, input int r_dly, input string tag);
        logic [31:0] d;
        logic [2:0]  r;
        r = m_read(a, d);
        do_read(a, r_dly, d, r, tag);
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [31:0] exp_data;
        logic [2:0]  exp_resp;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        logic [31:0] old_val, new_val, d;
        logic [7:0]  a;
        logic [3:0]  s;
        logic [2:0]  r;
        int          n, cnt, cyc;

        s_axi_areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
        m_reset();

        tbl[0]  = '{1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        3'd0};
        tbl[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 3'd0};
        tbl[2]  = '{1'b0, 8'h08, 32'h0,        4'h0, 0, 0, 32'h00000001, 3'd0};
        tbl[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 0, 0, 32'hA1100001, 3'd0};
        tbl[4]  = '{1'b1, 8'h0C, 32'h0BADF00D, 4'hF, 0, 0, 32'h0,        3'd2};
        tbl[5]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 0, 0, 32'hA1100001, 3'd0};
        tbl[6]  = '{1'b0, 8'h10, 32'h0,        4'h0, 0, 0, 32'h00000000, 3'd2};
        tbl[7]  = '{1'b1, 8'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,        3'd0};
        tbl[8]  = '{1'b1, 8'h04, 32'h12345678, 4'h5, 3, 0, 32'h0,        3'd0};
        tbl[9]  = '{1'b0, 8'h04, 32'h0,        4'h0, 0, 0, 32'hFF34FF78, 3'd0};
        tbl[10] = '{1'b1, 8'h00, 32'h55555555, 4'h0, 0, 0, 32'h0,        3'd0};
        tbl[11] = '{1'b0, 8'h00, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 3'd0};
        tbl[12] = '{1'b1, 8'h00, 32'h11223344, 4'hF, 0, 2, 32'h0,        3'd0};
        tbl[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 0, 0, 32'h11223344, 3'd0};
        tbl[14] = '{1'b1, 8'h09, 32'hCAFEBABE, 4'hF, 0, 0, 32'h0,        3'd2};
        tbl[15] = '{1'b1, 8'h08, 32'hCAFEBABE, 4'hF, 1, 0, 32'h0,        3'd2};
        tbl[16] = '{1'b0, 8'h02, 32'h0,        4'h0, 0, 0, 32'h00000000, 3'd2};
        tbl[17] = '{1'b0, 8'h08, 32'h0,        4'h0, 0, 0, 32'h00000005, 3'd0};
        tbl[18] = '{1'b0, 8'h04, 32'h0,        4'h0, 0, 0, 32'hFF34FF78, 3'd0};

        // Power-on reset: outputs held low while reset is high.
        repeat (3) @(negedge s_axi_aclk);
        check_reset_outputs("por");
        s_axi_areset = 1'b0;
        @(negedge s_axi_aclk);
        check("por release readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        // Reset between AW acceptance and W: nothing commits, outputs clear asynchronously.
        s_axi_awaddr = 8'h00; s_axi_awvalid = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_awvalid = 1'b0;
        check("mid aw latched readies", 32'({s_axi_awready, s_axi_wready}), 32'h1);
        #1 s_axi_areset = 1'b1;
        #1 check_reset_outputs("mid-txn reset");
        repeat (2) @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        m_reset();
        @(negedge s_axi_aclk);
        check("mid release readies/bvalid",
              32'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid}), 32'hE);
        do_read(8'h00, 0, 32'h0, 3'd0, "mid REG0");
        do_read(8'h08, 0, 32'h0, 3'd0, "mid WCOUNT");

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) begin
                r = m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, 0,
                         tbl[i].exp_resp, $sformatf("vec%0d", i));
            end else begin
                do_read(tbl[i].addr, 0, tbl[i].exp_data, tbl[i].exp_resp, $sformatf("vec%0d", i));
            end
        end

        // Back-pressured responses.
        r = m_write(8'h04, 32'hA5A5A5A5, 4'hF);
        do_write(8'h04, 32'hA5A5A5A5, 4'hF, 0, 0, 5, r, "stall wr");
        model_read(8'h04, 5, "stall rd");

        // AR accepted on the same edge that REG0 is written: read sees the old contents.
        old_val = m_reg[0];
        new_val = 32'h600DF00D;
        @(negedge s_axi_aclk);
        check("same-edge readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
        s_axi_awaddr = 8'h00; s_axi_wdata = new_val; s_axi_wstrb = 4'hF;
        s_axi_araddr = 8'h00;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("same-edge bvalid/rvalid", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h3);
        check("same-edge old rdata", s_axi_rdata, old_val);
        check("same-edge bresp", 32'(s_axi_bresp), 32'h0);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        r = m_write(8'h00, new_val, 4'hF);
        model_read(8'h00, 0, "same-edge new REG0");

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            n = $urandom_range(0, 5);
            a = (n < 4) ? 8'(n * 4) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                r = m_write(a, d, s);
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                         r, $sformatf("rnd%0d wr@%02h", i, a));
            end else begin
                model_read(a, $urandom_range(0, 2), $sformatf("rnd%0d rd@%02h", i, a));
            end
        end

        // Drive WCOUNT to 0xFFFF with back-to-back no-op writes, then one more wraps it.
        n = int'((65535 - m_wcount) % 65536);
        cnt = 0; cyc = 0;
        @(negedge s_axi_aclk);
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        while (cnt < n && cyc < 4 * n + 10) begin
            @(negedge s_axi_aclk);
            cyc++;
            if (s_axi_bvalid) cnt++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge s_axi_aclk);
        s_axi_bready = 1'b0;
        check("burst writes completed", 32'(cnt), 32'(n));
        m_wcount = (m_wcount + n) % 65536;
        do_read(8'h08, 0, 32'h0000FFFF, 3'd0, "wcount max");
        r = m_write(8'h04, 32'h0, 4'h0);
        do_write(8'h04, 32'h0, 4'h0, 0, 0, 0, 3'd0, "wrap wr");
        do_read(8'h08, 0, 32'h00000000, 3'd0, "wcount wrap");
        model_read(8'h0C, 0, "id final");

        // Reset after traffic clears every register.
        @(negedge s_axi_aclk);
        #1 s_axi_areset = 1'b1;
        #1 check_reset_outputs("final reset");
        @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        m_reset();
        @(negedge s_axi_aclk);
        check("final release readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
        model_read(8'h00, 0, "post-reset REG0");
        model_read(8'h04, 0, "post-reset REG1");
        model_read(8'h08, 0, "post-reset WCOUNT");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, response width; OKAY=0, SLVERR=2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of register 0.
REQ-005 SHALL have parameter ID_VALUE, default 32'hA110_0001, constant returned by the ID register.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, with the ports below.
REQ-007 s_axi_aclk  in  1  clock; all logic on the rising edge.
REQ-008 s_axi_areset  in  1  asynchronous active-high reset.
REQ-009 s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-010 s_axi_awvalid  in  1 / s_axi_awready  out  1  AW handshake.
REQ-011 s_axi_wdata  in  DATA_WIDTH  write data.
REQ-012 s_axi_wstrb  in  DATA_WIDTH/8  byte enables; bit i covers bits 8i+7:8i.
REQ-013 s_axi_wvalid  in  1 / s_axi_wready  out  1  W handshake.
REQ-014 s_axi_bresp  out  RESP_WIDTH / s_axi_bvalid  out  1 / s_axi_bready  in  1  B channel.
REQ-015 s_axi_araddr  in  ADDR_WIDTH / s_axi_arvalid  in  1 / s_axi_arready  out  1  AR channel.
REQ-016 s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  RESP_WIDTH / s_axi_rvalid  out  1 / s_axi_rready  in  1  R channel.

Function
REQ-017 SHALL decode offset = addr - BASE_ADDR: 0x00 REG0 (RW), 0x04 REG1 (RW), 0x08 WCOUNT (RO, 16-bit zero-extended), 0x0C ID (RO, ID_VALUE).
REQ-018 Any other offset, or addr[1:0]!=0, SHALL be unmapped.
REQ-019 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-020 In W_IDLE awready=1 and wready=1; AW and W SHALL be accepted independently, in either order or the same cycle.
REQ-021 After a handshake, that channel's ready SHALL be 0 until W_RESP exits; the address or data/strobe SHALL be latched.
REQ-022 On the edge where the second of AW and W completes, the write SHALL commit, bvalid SHALL rise, and the FSM SHALL enter W_RESP.
REQ-023 Commit to REG0/REG1 SHALL update only strobed bytes; wstrb=0 SHALL be an OKAY no-op.
REQ-024 Writes to WCOUNT, ID or unmapped offsets SHALL change no state and SHALL respond SLVERR; all others respond OKAY.
REQ-025 WCOUNT SHALL increment by 1 per OKAY write, including wstrb=0, and SHALL wrap 0xFFFF->0x0000.
REQ-026 bvalid/bresp SHALL hold stable until bready; on the handshake edge bvalid->0, the FSM returns to W_IDLE, and awready/wready are 1 the next cycle.
REQ-027 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (arready=0, rvalid=1).
REQ-028 On the arvalid&&arready edge, rdata/rresp SHALL be registered from pre-edge register contents, and rvalid SHALL rise the next cycle (1-cycle latency).
REQ-029 An unmapped read SHALL return rdata=0, rresp=SLVERR.
REQ-030 rdata/rresp/rvalid SHALL hold until rready; on the handshake edge the FSM returns to R_IDLE.
REQ-031 Read and write FSMs SHALL run concurrently; a read accepted on the same edge as a write commit to the same register SHALL return the old value.
REQ-032 Inputs SHALL be ignored whenever the corresponding ready is 0.

Reset
REQ-033 While s_axi_areset=1, asynchronously: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, REG0=REG1=0, WCOUNT=0, FSMs in W_IDLE/R_IDLE.
REQ-034 Reset mid-transaction SHALL abandon it without committing; readies SHALL be 1 on the first edge after release.

Verification
REQ-035 AW 0x00 and W 0xDEADBEEF/strb 0xF in the same cycle -> bvalid next cycle, bresp=0; read 0x00 returns 0xDEADBEEF, WCOUNT reads 1.
REQ-036 W before AW by 3 cycles (offset 0x04, data 0x12345678, strb 0x5) over REG1=0xFFFFFFFF -> REG1=0xFF34FF78, bresp=0.
REQ-037 Write 0x0C, then read 0x10 -> bresp=2, ID unchanged; rdata=0, rresp=2.
REQ-038 bready/rready held low 5 cycles -> bvalid/rvalid and payload stable, awready/arready stay 0 throughout.
REQ-039 Preload WCOUNT 0xFFFF via writes, one more write -> WCOUNT reads 0x0000; read REG0 on the commit edge of a write -> old value returned.
REQ-040 Assert reset after AW accepted, before W -> no commit, all outputs 0, REG0 unchanged at 0; readies=1 after release.
